nn_layer_sequencer: RTL and testbench

Parametrised successor to the single-neuron control unit. It sequences a full dense layer of N_NEURONS neurons, each with N_INPUTS inputs, by driving the address generator (AG) and the MAC ALU. It adds a start/done handshake, a stall input, a configurable reset-hold length and ALU pipeline latency, a per-neuron accumulator clear and a result write strobe. It sits between the top-level layer controller and the AG/ALU/result-memory datapath.

---
 rtl/nn_ctrl_pkg.sv | 45 ++++
 rtl/nn_valid_delay.sv | 27 ++
 rtl/nn_layer_sequencer.sv | 132 +++++++++++++
 tb/tb_nn_layer_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the neural-network control units: state encoding,
// default parameters and control-output bundle layout with its decoder.
package nn_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RSTH,
        ACCUM,
        DRAIN,
        WRITE,
        CLEAR,
        DONE
    } nn_state_e;

    localparam int unsigned DEF_N_INPUTS   = 4;
    localparam int unsigned DEF_N_NEURONS  = 3;
    localparam int unsigned DEF_RST_CYCLES = 2;
    localparam int unsigned DEF_PIPE_LAT   = 1;
    localparam int unsigned DEF_IN_IDX_W   = 8;
    localparam int unsigned DEF_NEU_IDX_W  = 8;

    // Bit positions inside the registered control bundle
    localparam int unsigned CTRL_AG_RST  = 0;
    localparam int unsigned CTRL_AG_READ = 1;
    localparam int unsigned CTRL_ALU_RST = 2;
    localparam int unsigned CTRL_WR_EN   = 3;
    localparam int unsigned CTRL_BUSY    = 4;
    localparam int unsigned CTRL_DONE    = 5;
    localparam int unsigned CTRL_W       = 6;

    typedef logic [CTRL_W-1:0] ctrl_t;

    function automatic ctrl_t ctrl_decode(nn_state_e s, logic rd);
        ctrl_t c;
        c               = '0;
        c[CTRL_AG_RST]  = (s == IDLE) || (s == RSTH);
        c[CTRL_ALU_RST] = (s == IDLE) || (s == RSTH) || (s == CLEAR);
        c[CTRL_AG_READ] = (s == ACCUM) && rd;
        c[CTRL_WR_EN]   = (s == WRITE);
        c[CTRL_BUSY]    = (s != IDLE);
        c[CTRL_DONE]    = (s == DONE);
        return c;
    endfunction

endpackage

// File: rtl/nn_valid_delay.sv
// Fixed-depth 1-bit valid delay line with synchronous active-low clear;
// turns the AG read strobe into the ALU accumulate enable.
module nn_valid_delay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/nn_layer_sequencer.sv
// Dense-layer sequencer: drives the address generator and MAC ALU through
// reset-hold, per-neuron accumulate/drain/write and a layer-done handshake.
module nn_layer_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int unsigned N_INPUTS   = DEF_N_INPUTS,
    parameter int unsigned N_NEURONS  = DEF_N_NEURONS,
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
    parameter int unsigned PIPE_LAT   = DEF_PIPE_LAT,
    parameter int unsigned IN_IDX_W   = DEF_IN_IDX_W,
    parameter int unsigned NEU_IDX_W  = DEF_NEU_IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    output logic                 AG_rst,
    output logic                 AG_read,
    output logic                 ALU_rst,
    output logic                 ALU_en,
    output logic                 wr_en,
    output logic [NEU_IDX_W-1:0] neuron_idx,
    output logic [IN_IDX_W-1:0]  input_idx,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned PH_MAX = (RST_CYCLES > PIPE_LAT) ? RST_CYCLES : PIPE_LAT;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    nn_state_e            state_q, state_d;
    logic [PH_W-1:0]      ph_q, ph_d;
    logic [IN_IDX_W-1:0]  in_q, in_d;
    logic [NEU_IDX_W-1:0] neu_q, neu_d;
    ctrl_t                ctrl_q, ctrl_d;
    logic                 rd_d;

    // Outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        in_d    = in_q;
        neu_d   = neu_q;
        rd_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RSTH;
                    ph_d    = PH_W'(1);
                    in_d    = '0;
                    neu_d   = '0;
                end
            end
            RSTH: begin
                if (ph_q == PH_W'(RST_CYCLES)) begin
                    state_d = ACCUM;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ACCUM: begin
                if (in_q == IN_IDX_W'(N_INPUTS)) begin
                    state_d = DRAIN;
                    ph_d    = PH_W'(1);
                end
            end
            DRAIN: begin
                if (ph_q == PH_W'(PIPE_LAT)) begin
                    state_d = WRITE;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            WRITE: begin
                if (neu_q == NEU_IDX_W'(N_NEURONS - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = CLEAR;
                    neu_d   = neu_q + 1'b1;
                    in_d    = '0;
                end
            end
            CLEAR:   state_d = ACCUM;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Every cycle spent in ACCUM issues a read unless stalled.
        if ((state_d == ACCUM) && !stall) begin
            rd_d = 1'b1;
            in_d = in_q + 1'b1;
        end

        ctrl_d = ctrl_decode(state_d, rd_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ph_q    <= '0;
            in_q    <= '0;
            neu_q   <= '0;
            ctrl_q  <= ctrl_decode(IDLE, 1'b0);
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            in_q    <= in_d;
            neu_q   <= neu_d;
            ctrl_q  <= ctrl_d;
        end
    end

    nn_valid_delay #(
        .DEPTH (PIPE_LAT)
    ) u_valid_delay (
        .clk_i  (clk),
        .rst_ni (reset),
        .d_i    (ctrl_q[CTRL_AG_READ]),
        .q_o    (ALU_en)
    );

    assign AG_rst     = ctrl_q[CTRL_AG_RST];
    assign AG_read    = ctrl_q[CTRL_AG_READ];
    assign ALU_rst    = ctrl_q[CTRL_ALU_RST];
    assign wr_en      = ctrl_q[CTRL_WR_EN];
    assign busy       = ctrl_q[CTRL_BUSY];
    assign done       = ctrl_q[CTRL_DONE];
    assign neuron_idx = neu_q;
    assign input_idx  = in_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: per-cycle comparison against a schedule-based
// reference model, plus fixed checkpoint tables for the nominal/stall/reset cases.
module tb_nn_layer_sequencer;

    localparam int H = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_start, a_stall;
    logic       a_agr, a_rd, a_alur, a_alue, a_wr, a_busy, a_done;
    logic [7:0] a_neu, a_inp;
    logic       b_reset, b_start, b_stall;
    logic       b_agr, b_rd, b_alur, b_alue, b_wr, b_busy, b_done;
    logic [7:0] b_neu, b_inp;

    nn_layer_sequencer #(
        .N_INPUTS(4), .N_NEURONS(2), .RST_CYCLES(2), .PIPE_LAT(1),
        .IN_IDX_W(8), .NEU_IDX_W(8)
    ) dut_a (
        .clk(clk), .reset(a_reset), .start(a_start), .stall(a_stall),
        .AG_rst(a_agr), .AG_read(a_rd), .ALU_rst(a_alur), .ALU_en(a_alue),
        .wr_en(a_wr), .neuron_idx(a_neu), .input_idx(a_inp),
        .busy(a_busy), .done(a_done)
    );

    nn_layer_sequencer #(
        .N_INPUTS(1), .N_NEURONS(1), .RST_CYCLES(2), .PIPE_LAT(3),
        .IN_IDX_W(8), .NEU_IDX_W(8)
    ) dut_b (
        .clk(clk), .reset(b_reset), .start(b_start), .stall(b_stall),
        .AG_rst(b_agr), .AG_read(b_rd), .ALU_rst(b_alur), .ALU_en(b_alue),
        .wr_en(b_wr), .neuron_idx(b_neu), .input_idx(b_inp),
        .busy(b_busy), .done(b_done)
    );

    // Stimulus per edge k: st = start, sl = stall, rl = reset held low
    bit st[H], sl[H], rl[H];
    logic [22:0] exp_v[H], got_v[H];
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit idle; bit agr; bit rd; bit alur; bit wr; bit bsy; bit dn;
        int neu; int inp;
    } cyc_t;
    cyc_t m[H];

    typedef struct {
        int scen; int k; logic [6:0] fl; int neu; int inp;
    } chk_t;
    chk_t tbl[$];

    function automatic void add(int scen, int k, logic [6:0] fl, int neu, int inp);
        chk_t c;
        c.scen = scen; c.k = k; c.fl = fl; c.neu = neu; c.inp = inp;
        tbl.push_back(c);
    endfunction

    function automatic void put(int t, bit rd, bit alur, bit wr, bit dn, int neu, int inp);
        if (t < H) begin
            m[t] = '{0, 0, rd, alur, wr, 1, dn, neu, inp};
        end
    endfunction

    // Lays out one layer started by the edge s; returns the cycle of its done pulse.
    function automatic int run_layer(int s, int ni, int nn, int r, int p);
        int t = s;
        for (int i = 0; i < r; i++) begin
            put(t, 0, 1, 0, 0, 0, 0);
            m[t < H ? t : H-1].agr = (t < H) ? 1'b1 : m[H-1].agr;
            t++;
        end
        for (int n = 0; n < nn; n++) begin
            int reads = 0;
            if (n > 0) begin
                put(t, 0, 1, 0, 0, n, 0);
                t++;
            end
            while (reads < ni) begin
                bit rd = (t < H) ? !sl[t] : 1'b1;
                if (rd) reads++;
                put(t, rd, 0, 0, 0, n, reads);
                t++;
            end
            for (int i = 0; i < p; i++) begin
                put(t, 0, 0, 0, 0, n, ni);
                t++;
            end
            put(t, 0, 0, 1, 0, n, ni);
            t++;
        end
        put(t, 0, 0, 0, 1, nn - 1, ni);
        return t;
    endfunction

    task automatic build_model(input int ni, input int nn, input int r, input int p);
        int bu = -2;
        for (int t = 0; t < H; t++) m[t] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int e = 0; e < H; e++) begin
            if (rl[e]) begin
                for (int t = e; t < H; t++) m[t] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
                bu = e - 1;
            end else if (st[e] && (e - 1 > bu)) begin
                bu = run_layer(e, ni, nn, r, p);
            end
        end
        for (int t = 0; t < H; t++) begin
            if (m[t].idle) begin
                m[t].agr  = 1;
                m[t].alur = 1;
                m[t].neu  = (t == 0 || rl[t]) ? 0 : m[t-1].neu;
                m[t].inp  = (t == 0 || rl[t]) ? 0 : m[t-1].inp;
            end
        end
        for (int t = 0; t < H; t++) begin
            bit alu = (t >= p) ? m[t-p].rd : 1'b0;
            for (int j = t - p + 1; j <= t; j++) begin
                if (j >= 0 && rl[j]) alu = 0;
            end
            exp_v[t] = {m[t].agr, m[t].rd, m[t].alur, alu, m[t].wr, m[t].bsy, m[t].dn,
                        8'(m[t].neu), 8'(m[t].inp)};
        end
    endtask

    task automatic clr();
        for (int k = 0; k < H; k++) begin
            st[k] = 0; sl[k] = 0; rl[k] = 0;
        end
        rl[0] = 1;
        rl[1] = 1;
    endtask

    task automatic run(input bit use_b, input string name);
        logic [22:0] got;
        for (int k = 0; k < H; k++) begin
            @(negedge clk);
            a_reset = use_b ? 1'b0 : !rl[k];
            a_start = use_b ? 1'b0 : st[k];
            a_stall = use_b ? 1'b0 : sl[k];
            b_reset = use_b ? !rl[k] : 1'b0;
            b_start = use_b ? st[k] : 1'b0;
            b_stall = use_b ? sl[k] : 1'b0;
            @(posedge clk);
            #1;
            if (use_b)
                got = {b_agr, b_rd, b_alur, b_alue, b_wr, b_busy, b_done, b_neu, b_inp};
            else
                got = {a_agr, a_rd, a_alur, a_alue, a_wr, a_busy, a_done, a_neu, a_inp};
            got_v[k] = got;
            vectors++;
            if (got !== exp_v[k]) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got flags=%b neu=%0d in=%0d, expected flags=%b neu=%0d in=%0d",
                         name, k, got[22:16], got[15:8], got[7:0],
                         exp_v[k][22:16], exp_v[k][15:8], exp_v[k][7:0]);
            end
        end
    endtask

    // Checkpoint k is the test-plan cycle; the start edge is 3, so plan cycle k is cycle 2+k.
    task automatic check_table(input int scen);
        foreach (tbl[i]) begin
            if (tbl[i].scen == scen) begin
                logic [22:0] want = {tbl[i].fl, 8'(tbl[i].neu), 8'(tbl[i].inp)};
                vectors++;
                if (got_v[2 + tbl[i].k] !== want) begin
                    miscompares++;
                    $display("FAIL table scen %0d plan cycle %0d: got %h, expected %h",
                             scen, tbl[i].k, got_v[2 + tbl[i].k], want);
                end
            end
        end
    endtask

    initial begin
        a_reset = 0; a_start = 0; a_stall = 0;
        b_reset = 0; b_start = 0; b_stall = 0;

        // flags = {AG_rst, AG_read, ALU_rst, ALU_en, wr_en, busy, done}
        add(1, 0,  7'b1010000, 0, 0);
        add(1, 1,  7'b1010010, 0, 0);
        add(1, 2,  7'b1010010, 0, 0);
        add(1, 3,  7'b0100010, 0, 1);
        add(1, 4,  7'b0101010, 0, 2);
        add(1, 6,  7'b0101010, 0, 4);
        add(1, 7,  7'b0001010, 0, 4);
        add(1, 8,  7'b0000110, 0, 4);
        add(1, 9,  7'b0010010, 1, 0);
        add(1, 10, 7'b0100010, 1, 1);
        add(1, 13, 7'b0101010, 1, 4);
        add(1, 14, 7'b0001010, 1, 4);
        add(1, 15, 7'b0000110, 1, 4);
        add(1, 16, 7'b0000011, 1, 4);
        add(1, 17, 7'b1010000, 1, 4);
        add(2, 3,  7'b0100010, 0, 1);
        add(2, 4,  7'b0001010, 0, 1);
        add(2, 5,  7'b0000010, 0, 1);
        add(2, 6,  7'b0100010, 0, 2);
        add(2, 7,  7'b0101010, 0, 3);
        add(2, 8,  7'b0101010, 0, 4);
        add(2, 9,  7'b0001010, 0, 4);
        add(2, 10, 7'b0000110, 0, 4);
        add(3, 10, 7'b0100010, 1, 1);
        add(3, 11, 7'b1010000, 0, 0);
        add(3, 12, 7'b1010000, 0, 0);

        clr(); st[3] = 1;
        build_model(4, 2, 2, 1); run(0, "nominal"); check_table(1);

        clr(); st[3] = 1; sl[6] = 1; sl[7] = 1; sl[30] = 1;
        build_model(4, 2, 2, 1); run(0, "stall"); check_table(2);

        clr(); st[3] = 1; rl[13] = 1; st[40] = 1;
        build_model(4, 2, 2, 1); run(0, "reset_mid"); check_table(3);

        clr(); st[3] = 1; st[7] = 1; st[14] = 1; sl[1] = 1; sl[12] = 1;
        build_model(4, 2, 2, 1); run(0, "start_busy");

        clr(); for (int k = 0; k < H; k++) st[k] = 1;
        build_model(4, 2, 2, 1); run(0, "start_held");

        for (int n = 0; n < 4; n++) begin
            clr();
            for (int k = 2; k < H; k++) begin
                st[k] = ($urandom_range(0, 9) == 0);
                sl[k] = ($urandom_range(0, 2) == 0);
                rl[k] = ($urandom_range(0, 59) == 0);
            end
            build_model(4, 2, 2, 1); run(0, "random_a");
        end

        clr(); st[3] = 1;
        build_model(1, 1, 2, 3); run(1, "sweep_nominal");

        clr(); for (int k = 0; k < H; k++) st[k] = 1;
        build_model(1, 1, 2, 3); run(1, "sweep_held");

        for (int n = 0; n < 2; n++) begin
            clr();
            for (int k = 2; k < H; k++) begin
                st[k] = ($urandom_range(0, 5) == 0);
                sl[k] = ($urandom_range(0, 1) == 0);
                rl[k] = ($urandom_range(0, 49) == 0);
            end
            build_model(1, 1, 2, 3); run(1, "random_b");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
